// File: rtl/mem_bus_port_pkg.sv
// Shared definitions for the memory bus port: FSM encoding, read/write
// encoding, default widths and a helper for sizing the timeout counter.
package mem_bus_port_pkg;

  localparam int unsigned DEF_WORD_WIDTH = 16;
  localparam int unsigned DEF_ADDR_WIDTH = 16;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [STATE_W-1:0] ST_ACCESS  = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE    = 2'd2;
  localparam logic [STATE_W-1:0] ST_RELEASE = 2'd3;

  localparam logic R_W_READ  = 1'b0;
  localparam logic R_W_WRITE = 1'b1;

  // Bits needed for a counter running 0..limit-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/mem_bus_port_if.sv
// Bus/memory handshake bundle for mem_bus_port.
//   slave  : the port block (samples bus/control/memory, drives MAR/MDR,
//            memory request and ready/err)
//   master : the surrounding datapath, control FSM and memory
interface mem_bus_port_if
  import mem_bus_port_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WORD_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic [WIDTH-1:0]      bus;
  logic                  ld_mar;
  logic                  ld_mdr;
  logic                  mio_en;
  logic                  r_w;
  logic [WIDTH-1:0]      mem_rdata;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mar;
  logic [WIDTH-1:0]      mdr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_wdata;
  logic                  mem_req;
  logic                  mem_we;
  logic                  ready;
  logic                  err;

  modport slave (
    input  bus, ld_mar, ld_mdr, mio_en, r_w, mem_rdata, mem_ready,
    output mar, mdr, mem_addr, mem_wdata, mem_req, mem_we, ready, err
  );

  modport master (
    output bus, ld_mar, ld_mdr, mio_en, r_w, mem_rdata, mem_ready,
    input  mar, mdr, mem_addr, mem_wdata, mem_req, mem_we, ready, err
  );

endinterface

// File: rtl/mem_bus_timer.sv
// Access timeout counter. clr_i reloads the count to zero, en_i advances it.
// tc_o is registered and is high while the count equals LIMIT-1; LIMIT=0
// keeps tc_o low permanently.
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : reload count to zero (has priority over en_i)
//   en_i     : increment count
//   tc_o     : terminal count reached
module mem_bus_timer
  import mem_bus_port_pkg::*;
#(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CNT_W = cnt_width(LIMIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);
  localparam bit ENABLED = (LIMIT != 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;

  // Next count; terminal flag is precomputed so tc_o needs no decode.
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = tc_q;
    if (clr_i) begin
      cnt_d = '0;
      tc_d  = ENABLED && (LAST == '0);
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      tc_d  = ENABLED && (cnt_d == LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/mem_bus_port.sv
// Receiving end of the shared datapath bus: MAR/MDR registers and the
// memory access handshake toward memory / memory-mapped I/O, with a
// one-cycle ready pulse back to the control state machine.
//   clk, rst       : clock, synchronous active-high reset
//   bif (slave)    : bus, ld_mar, ld_mdr, mio_en, r_w, mem_rdata, mem_ready in;
//                    mar, mdr, mem_addr, mem_wdata, mem_req, mem_we,
//                    ready, err out
module mem_bus_port
  import mem_bus_port_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WORD_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic           clk,
  input  logic           rst,
  mem_bus_port_if.slave  bif
);

  logic [STATE_W-1:0]    state_q,   state_d;
  logic [ADDR_WIDTH-1:0] mar_q,     mar_d;
  logic [WIDTH-1:0]      mdr_q,     mdr_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q,  mem_we_d;
  logic                  ready_q,   ready_d;
  logic                  err_q,     err_d;
  logic                  tmr_clr_c, tmr_en_c, tmr_tc;

  // Timer runs only inside ACCESS and is held cleared everywhere else.
  mem_bus_timer #(
    .LIMIT (TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (tmr_clr_c),
    .en_i  (tmr_en_c),
    .tc_o  (tmr_tc)
  );

  // Next-state and register updates.
  always_comb begin
    state_d   = state_q;
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    mem_req_d = mem_req_q;
    mem_we_d  = mem_we_q;
    ready_d   = 1'b0;
    err_d     = err_q;
    tmr_clr_c = 1'b1;
    tmr_en_c  = 1'b0;

    case (state_q)
      ST_IDLE, ST_RELEASE: begin
        if (bif.ld_mar) mar_d = bif.bus[ADDR_WIDTH-1:0];
        if (bif.ld_mdr && !bif.mio_en) mdr_d = bif.bus;
        if (state_q == ST_IDLE) begin
          if (bif.mio_en) begin
            state_d   = ST_ACCESS;
            mem_req_d = 1'b1;
            mem_we_d  = bif.r_w;
          end
        end else if (!bif.mio_en) begin
          state_d = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        tmr_clr_c = 1'b0;
        tmr_en_c  = 1'b1;
        // Completion beats timeout when both land on the same cycle.
        if (bif.mem_ready) begin
          if (mem_we_q == R_W_READ) mdr_d = bif.mem_rdata;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          ready_d   = 1'b1;
          state_d   = ST_DONE;
        end else if (tmr_tc) begin
          err_d     = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          ready_d   = 1'b1;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        // A still-held mio_en parks in RELEASE so it cannot retrigger.
        state_d = bif.mio_en ? ST_RELEASE : ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mar_q     <= '0;
      mdr_q     <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  assign bif.mar       = mar_q;
  assign bif.mdr       = mdr_q;
  assign bif.mem_addr  = mar_q;
  assign bif.mem_wdata = mdr_q;
  assign bif.mem_req   = mem_req_q;
  assign bif.mem_we    = mem_we_q;
  assign bif.ready     = ready_q;
  assign bif.err       = err_q;

endmodule

// File: doc/mem_bus_port.md
Name: mem_bus_port

Overview:
- Receiving end of the shared 16-bit processor bus that the gated tristate drivers feed.
- Holds the MAR and MDR registers, which load from the bus or from memory.
- Runs the memory access handshake: request/ready toward the memory, and a one-cycle ready (R) back to the control state machine.
- Sits between the datapath bus and the memory / memory-mapped I/O block. Driving MDR back onto the bus is done by a separate tristate gate outside this block.

Parameters:
- WIDTH, 16, data/bus width in bits.
- ADDR_WIDTH, 16, address width in bits; must be ≤ WIDTH, and MAR takes bus[ADDR_WIDTH-1:0].
- TIMEOUT, 64, number of ACCESS cycles before the access is abandoned; 0 disables the timeout.

Ports:
- clk  in  1  single clock; every register updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- bus  in  WIDTH  shared datapath bus, sampled when loading.
- ld_mar  in  1  load MAR from the bus.
- ld_mdr  in  1  load MDR from the bus when mio_en=0.
- mio_en  in  1  request a memory access, held by the control state machine.
- r_w  in  1  0 = read, 1 = write; sampled on entry to ACCESS.
- mem_rdata  in  WIDTH  memory read data, valid while mem_ready=1.
- mem_ready  in  1  memory completion strobe.
- mar  out  ADDR_WIDTH  MAR register.
- mdr  out  WIDTH  MDR register; feeds the external bus gate.
- mem_addr  out  ADDR_WIDTH  equals mar (combinational).
- mem_wdata  out  WIDTH  equals mdr (combinational).
- mem_req  out  1  registered access request.
- mem_we  out  1  registered write enable; qualified by mem_req.
- ready  out  1  R to the control state machine; one-cycle pulse.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset: mar=0, mdr=0, mem_req=0, mem_we=0, ready=0, err=0, counter=0, state=IDLE. Reset overrides everything, including a mid-access cycle; memory sees mem_req drop on the next cycle.
- States: IDLE, ACCESS, DONE, RELEASE.
- IDLE:
  - ld_mar: mar<=bus[ADDR_WIDTH-1:0].
  - ld_mdr && !mio_en: mdr<=bus.
  - mio_en: go to ACCESS; mem_req<=1, mem_we<=r_w, counter<=0.
  - ld_mar and mio_en in the same cycle: both take effect. The request starts the next cycle using the newly loaded MAR.
- ACCESS:
  - mar is frozen (ld_mar ignored) and mdr is frozen (ld_mdr ignored).
  - mem_ready=1: mem_req<=0, mem_we<=0, go to DONE. On a read, mdr<=mem_rdata on the same edge.
  - Otherwise counter increments. If TIMEOUT≠0 and counter==TIMEOUT-1 while mem_ready=0: err<=1, mem_req<=0, mem_we<=0, mdr unchanged, go to DONE.
  - mem_ready wins over timeout when both occur in the same cycle.
  - mio_en dropping mid-access does not abort; the access runs to completion.
- DONE:
  - ready=1 for exactly this one cycle.
  - Go to RELEASE if mio_en=1, else IDLE.
- RELEASE:
  - ready=0; wait for mio_en=0, then go to IDLE.
  - Prevents a held mio_en from starting a second access.
  - ld_mar and ld_mdr are honoured as in IDLE.
- Latency:
  - Best case, mio_en sampled in cycle 0: mem_req high in cycle 1. If mem_ready=1 in cycle 1, ready is high in cycle 2 and mdr holds read data from cycle 2.
  - Total is 2 + memory wait cycles.
- mem_ready outside ACCESS is ignored.
- err clears only on rst.

Decomposition:
- Shared package holds:
  - State encoding: IDLE=2'd0, ACCESS=2'd1, DONE=2'd2, RELEASE=2'd3.
  - R_W_READ=1'b0 and R_W_WRITE=1'b1.
  - Default widths: WORD_WIDTH=16, ADDR_WIDTH=16.
- One natural sub-module: mem_bus_timer, the loadable timeout counter with clear/enable and a terminal-count output.
- MAR/MDR registers and the FSM stay in mem_bus_port.

Test Plan:
- Reset mid-access: rst during ACCESS with mar=16'h3000 → next cycle mar=0, mdr=0, mem_req=0, ready=0, state IDLE.
- Read, 3 wait states:
  - Stimulus: bus=16'h3000 with ld_mar, then mio_en=1, r_w=0; mem_ready pulses on the 4th ACCESS cycle with mem_rdata=16'hBEEF.
  - Response: mem_addr=16'h3000 throughout, mdr=16'hBEEF, ready high exactly one cycle, mem_we=0 throughout.
- Write:
  - Stimulus: ld_mdr with bus=16'h1234 (mio_en=0), ld_mar 16'hFE02, mio_en=1, r_w=1, mem_ready after 1 cycle.
  - Response: mem_we=1 and mem_wdata=16'h1234 while mem_req=1; mdr stays 16'h1234.
- Held mio_en: mio_en kept high 10 cycles past ready → exactly one mem_req burst and one ready pulse; ld_mar during ACCESS leaves mar unchanged.
- Timeout (TIMEOUT=4, no mem_ready):
  - Response: mem_req drops after 4 ACCESS cycles, err=1 and stays 1, ready pulses once, mdr unchanged.
  - Same-cycle mem_ready and terminal count: data captured, err=0.
- Back-to-back: ld_mar and mio_en asserted in the same cycle → the access uses the new MAR value.
